// File: rtl/concat_feed_pkg.sv
// Shared parameter header for the concat feed: parallelism, scaler latency
// and the types shared by the feed FSM and its job configuration.
package concat_feed_pkg;

  localparam int PARA_PICTURE_NUM   = 1;
  localparam int PARA_SCALER_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE,
    BR_A,
    BR_B,
    FIN
  } feed_state_t;

  typedef struct packed {
    logic [15:0] a_blocks;
    logic [15:0] b_blocks;
    logic [19:0] pixels;
    logic [31:0] scale_a;
    logic [31:0] scale_b;
  } job_cfg_t;

  function automatic int beat_w(input int pictures, input int channels);
    return pictures * channels * 32;
  endfunction

endpackage

// File: rtl/concat_feed_if.sv
// Beat streams of the concat feed: two branch inputs and the merged output
// toward the concat scaler.
interface concat_feed_if #(
  parameter int BEAT_W = 512
);

  logic [BEAT_W-1:0] a_data;
  logic              a_valid;
  logic              a_ready;
  logic [BEAT_W-1:0] b_data;
  logic              b_valid;
  logic              b_ready;
  logic              out_ready;
  logic [BEAT_W-1:0] concat_data_out;
  logic [31:0]       scale_out;
  logic              out_valid;
  logic              out_last;

  modport master (
    output a_data, a_valid, b_data, b_valid, out_ready,
    input  a_ready, b_ready, concat_data_out, scale_out, out_valid, out_last
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid, out_ready,
    output a_ready, b_ready, concat_data_out, scale_out, out_valid, out_last
  );

endinterface

// File: rtl/concat_feed_valid_delay.sv
// Fixed-depth shift register that lines the valid/last sideband up with
// the output of the concat scaler pipeline.
module concat_valid_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/concat_feed.sv
// Merges branch A and branch B beat streams pixel by pixel (all A beats, then
// all B beats) into the concat scaler, tagging each beat with its branch scale.
module concat_feed
  import concat_feed_pkg::*;
#(
  parameter int PICTURE_NUM       = concat_feed_pkg::PARA_PICTURE_NUM,
  parameter int RE_CHANNEL_IN_NUM = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   ch_a_blocks,
  input  logic [15:0]   ch_b_blocks,
  input  logic [19:0]   pixel_num,
  input  logic [31:0]   scale_a,
  input  logic [31:0]   scale_b,
  concat_feed_if.slave  bus,
  output logic          scaled_valid,
  output logic          scaled_last,
  output logic          busy,
  output logic          done
);

  localparam int BEAT_W = beat_w(PICTURE_NUM, RE_CHANNEL_IN_NUM);

  feed_state_t       state;
  job_cfg_t          cfg;
  logic [15:0]       beat_cnt;
  logic [19:0]       pix_cnt;
  logic              acc_a;
  logic              acc_b;
  logic              a_final;
  logic              b_final;
  logic              pix_final;
  logic              beat_last;
  logic [BEAT_W-1:0] sel_data;
  logic [1:0]        scaled_bits;

  // Readies are gated by rst so nothing can be accepted while reset is held.
  assign bus.a_ready = !rst && (state == BR_A) && bus.out_ready;
  assign bus.b_ready = !rst && (state == BR_B) && bus.out_ready;
  assign acc_a       = bus.a_valid && bus.a_ready;
  assign acc_b       = bus.b_valid && bus.b_ready;
  assign a_final     = (beat_cnt == cfg.a_blocks - 16'd1);
  assign b_final     = (beat_cnt == cfg.b_blocks - 16'd1);
  assign pix_final   = (pix_cnt == cfg.pixels - 20'd1);
  assign beat_last   = pix_final && ((acc_a && a_final && (cfg.b_blocks == 16'd0)) ||
                                     (acc_b && b_final));
  assign sel_data    = acc_a ? bus.a_data : bus.b_data;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cfg      <= '0;
      beat_cnt <= '0;
      pix_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cfg      <= '{ch_a_blocks, ch_b_blocks, pixel_num, scale_a, scale_b};
            beat_cnt <= '0;
            pix_cnt  <= '0;
            if ((pixel_num == 20'd0) || ((ch_a_blocks == 16'd0) && (ch_b_blocks == 16'd0))) begin
              state <= FIN;
            end else if (ch_a_blocks == 16'd0) begin
              state <= BR_B;
            end else begin
              state <= BR_A;
            end
          end
        end
        BR_A: begin
          if (acc_a) begin
            if (a_final) begin
              beat_cnt <= '0;
              if (cfg.b_blocks != 16'd0) begin
                state <= BR_B;
              end else if (pix_final) begin
                state <= FIN;
              end else begin
                pix_cnt <= pix_cnt + 20'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        BR_B: begin
          if (acc_b) begin
            if (b_final) begin
              beat_cnt <= '0;
              if (pix_final) begin
                state <= FIN;
              end else begin
                pix_cnt <= pix_cnt + 20'd1;
                state   <= (cfg.a_blocks != 16'd0) ? BR_A : BR_B;
              end
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and scale hold their last values between beats; only valid/last pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.concat_data_out <= '0;
      bus.scale_out       <= '0;
      bus.out_valid       <= 1'b0;
      bus.out_last        <= 1'b0;
    end else begin
      bus.out_valid <= acc_a || acc_b;
      bus.out_last  <= beat_last;
      if (acc_a || acc_b) begin
        bus.concat_data_out <= sel_data;
        bus.scale_out       <= acc_a ? cfg.scale_a : cfg.scale_b;
      end
    end
  end

  concat_valid_delay #(
    .DEPTH (PARA_SCALER_LATENCY),
    .WIDTH (2)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({bus.out_valid, bus.out_last}),
    .dout (scaled_bits)
  );

  assign scaled_valid = scaled_bits[1];
  assign scaled_last  = scaled_bits[0];

endmodule

// File: doc/concat_feed.md
CONCAT_FEED -- requirements
Module: concat_feed

Interface
REQ-001 SHALL have parameter PICTURE_NUM, default `PICTURE_NUM from the shared Para header, giving the number of pictures processed in parallel.
REQ-002 SHALL have parameter RE_CHANNEL_IN_NUM, default 16, giving the channels per beat.
REQ-003 SHALL define BEAT_W as PICTURE_NUM*RE_CHANNEL_IN_NUM*32, the beat width in bits.
REQ-004 Port clk, input, 1: sole clock; all logic on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle pulse that launches a concat job.
REQ-007 Port ch_a_blocks, input, 16: beats per pixel from branch A.
REQ-008 Port ch_b_blocks, input, 16: beats per pixel from branch B.
REQ-009 Port pixel_num, input, 20: pixels in the job.
REQ-010 Port scale_a, input, 32: requant scale for branch A.
REQ-011 Port scale_b, input, 32: requant scale for branch B.
REQ-012 Ports a_data (input, BEAT_W), a_valid (input, 1) and a_ready (output, 1) form the branch A stream.
REQ-013 Ports b_data (input, BEAT_W), b_valid (input, 1) and b_ready (output, 1) form the branch B stream.
REQ-014 Port out_ready, input, 1: downstream credit available.
REQ-015 Ports concat_data_out (output, BEAT_W) and scale_out (output, 32) carry data and scale into the concat scaler.
REQ-016 Ports out_valid (output, 1) and out_last (output, 1) qualify the beat on concat_data_out.
REQ-017 Ports scaled_valid (output, 1) and scaled_last (output, 1) are the sideband aligned to the scaler output.
REQ-018 Ports busy (output, 1) and done (output, 1) report job status.

Function
REQ-019 SHALL use a four-state FSM: IDLE, BR_A, BR_B, FIN.
REQ-020 In IDLE, start SHALL latch ch_a_blocks, ch_b_blocks, pixel_num, scale_a and scale_b; start is ignored in every other state.
REQ-021 On start, the FSM SHALL go to FIN when pixel_num==0 or both block counts are 0, to BR_B when ch_a_blocks==0, and to BR_A otherwise.
REQ-022 a_ready SHALL equal (state==BR_A) && out_ready.
REQ-023 b_ready SHALL equal (state==BR_B) && out_ready.
REQ-024 A beat is accepted when valid && ready on the active branch.
REQ-025 An accepted beat SHALL appear on concat_data_out one cycle later with out_valid=1.
REQ-026 scale_out SHALL carry the latched scale of the accepted beat's branch, registered together with the data.
REQ-027 With no accepted beat, out_valid SHALL be 0, and concat_data_out and scale_out SHALL hold their last values.
REQ-028 A beat counter SHALL advance on each accepted beat; after the final A beat of a pixel the FSM SHALL go to BR_B, or to the next pixel's BR_A when ch_b_blocks==0.
REQ-029 After the final B beat of a pixel the FSM SHALL go to BR_A of the next pixel (BR_B when ch_a_blocks==0), or to FIN when that pixel was the last.
REQ-030 out_last SHALL be 1 only with the final beat of the final pixel.
REQ-031 FIN SHALL drive done=1 for exactly one cycle and then return to IDLE.
REQ-032 busy SHALL be 1 in BR_A, BR_B and FIN.
REQ-033 A valid asserted on the inactive branch SHALL be ignored, with its ready held at 0.
REQ-034 A 4-stage shift register SHALL delay out_valid and out_last, so scaled_valid and scaled_last are out_valid and out_last 4 cycles earlier, matching the scaler's 3-cycle multiply plus 1-cycle judge.
REQ-035 With out_ready held at 1 and the active branch valid every cycle, throughput SHALL be one beat per cycle with no bubble at A-to-B, B-to-A or pixel boundaries.
REQ-036 Total accepted beats SHALL equal pixel_num*(ch_a_blocks+ch_b_blocks).

Reset
REQ-037 rst SHALL force state to IDLE and clear all counters.
REQ-038 rst SHALL clear out_valid, out_last, the delay line, scaled_valid, scaled_last, busy and done to 0.
REQ-039 rst SHALL clear concat_data_out, scale_out and the latched parameters to 0.
REQ-040 a_ready and b_ready SHALL be 0 during reset.
REQ-041 Asserting rst mid-job SHALL abort the job with no done pulse, and no scaled_valid SHALL emerge afterwards.

Structure
REQ-042 PICTURE_NUM and the scaler latency constant (4) SHALL be defined in the shared Para header, not locally.
REQ-043 The latency delay line SHALL be a sub-module, concat_valid_delay, parameterized by depth and width.

Verification
REQ-044 pixel_num=2, ch_a=3, ch_b=2, scale_a=0x100, scale_b=0x200, out_ready=1, valids always 1 -> 10 consecutive out_valid; scale_out sequence A,A,A,B,B per pixel; out_last on beat 10; done 1 cycle after; scaled_valid pattern shifted by 4 cycles.
REQ-045 ch_b=0, pixel_num=3, ch_a=2 -> 6 beats, all from A; b_ready never 1.
REQ-046 pixel_num=0, or ch_a=ch_b=0 -> done one cycle after FIN entry; no out_valid.
REQ-047 out_ready toggled 1,0,1,0 mid-job -> no beat accepted while out_ready=0; ordering and count preserved.
REQ-048 rst asserted after 4 accepted beats -> busy=0 and out_valid=0 next cycle; scaled_valid stays 0; a new start then completes normally.
REQ-049 start pulsed during BR_A -> ignored; latched parameters unchanged.
